fpalu_sequencer: RTL and testbench

- Arbitrates two independent requesters (port 0, port 1) onto the single shared fpalu adder/multiplier datapath.
- Sequences each operation: latch operands, pulse the datapath's active-low reset, hold operands and op steady, wait for done, then return the result with the requester id.
- A watchdog terminates stuck operations.
- Sits between client FSMs and the fpalu instance; it is the only driver of fpalu inputs.

---
 rtl/fpalu_sequencer.sv | 142 ++++++++++++++
 tb/tb_fpalu_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpalu_sequencer.sv
// fpalu_sequencer: shares one fpalu adder/multiplier between two requesters.
// Each operation latches its operands, pulses the datapath reset for one cycle,
// waits for a qualified done (or the watchdog), then holds the response until
// the consumer takes it. Only one operation is ever in flight.
module fpalu_sequencer #(
  parameter int TIMEOUT_CYC = 64,
  parameter int SETTLE_CYC  = 2,
  parameter int CNT_W       = 7
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_flow,
  output logic        rsp_timeout,

  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_op,
  output logic        alu_rst_n,
  input  logic [31:0] alu_result,
  input  logic        alu_flow,
  input  logic        alu_done
);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    WAIT,
    RESP
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_CNT   = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state;
  logic             last_grant;
  logic             cur_id;
  logic [CNT_W-1:0] wait_cnt;
  logic             grant_id;
  logic             accept;
  logic             done_qual;

  // Round-robin choice: alternate when both ask, otherwise serve whoever asks
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid)
      grant_id = ~last_grant;
    else if (req1_valid)
      grant_id = 1'b1;
  end

  // Ready is offered only in IDLE and never while the block is held in reset
  assign req0_ready = reset && (state == IDLE) && req0_valid && !grant_id;
  assign req1_ready = reset && (state == IDLE) && req1_valid &&  grant_id;
  assign accept     = req0_ready || req1_ready;

  // Done is only trusted once the settle window has passed, since the
  // datapath may still present done from the previous operation
  assign done_qual  = alu_done && (wait_cnt >= SETTLE_CNT);

  // Sequencer FSM with all datapath and response outputs registered
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      cur_id      <= 1'b0;
      wait_cnt    <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= 1'b0;
      alu_rst_n   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_result  <= '0;
      rsp_flow    <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          alu_rst_n <= 1'b1;
          if (accept) begin
            alu_op     <= grant_id ? req1_op : req0_op;
            alu_a      <= grant_id ? req1_a  : req0_a;
            alu_b      <= grant_id ? req1_b  : req0_b;
            cur_id     <= grant_id;
            last_grant <= grant_id;
            alu_rst_n  <= 1'b0;
            state      <= CLEAR;
          end
        end
        CLEAR: begin
          alu_rst_n <= 1'b1;
          wait_cnt  <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          if (done_qual) begin
            rsp_result  <= alu_result;
            rsp_flow    <= alu_flow;
            rsp_timeout <= 1'b0;
            rsp_id      <= cur_id;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            rsp_result  <= '0;
            rsp_flow    <= 1'b0;
            rsp_timeout <= 1'b1;
            rsp_id      <= cur_id;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpalu_sequencer.sv
// tb_fpalu_sequencer: drives two requesters and a stand-in fpalu, and predicts
// grants, response timing and response contents from a transaction-level model.
module tb_fpalu_sequencer;

  localparam int TIMEOUT_CYC = 64;
  localparam int SETTLE_CYC  = 2;
  localparam int CNT_W       = 7;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req0_op = 1'b0;
  logic [31:0] req0_a = '0, req0_b = '0;
  logic        req1_valid = 1'b0, req1_op = 1'b0;
  logic [31:0] req1_a = '0, req1_b = '0;
  logic        req0_ready, req1_ready;
  logic        rsp_valid, rsp_id, rsp_flow, rsp_timeout;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_op, alu_rst_n, alu_flow, alu_done;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  fpalu_sequencer #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .SETTLE_CYC (SETTLE_CYC),
    .CNT_W      (CNT_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flow   (rsp_flow),
    .rsp_timeout(rsp_timeout),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_rst_n  (alu_rst_n),
    .alu_result (alu_result),
    .alu_flow   (alu_flow),
    .alu_done   (alu_done)
  );

  typedef enum {NORMAL, STALE, STUCK} stub_mode_t;
  stub_mode_t stubMode = NORMAL;
  int  stubLat   = 1;
  int  stubCnt   = 0;
  bit  stubArmed = 1'b0;

  // Reference datapath: exact for the IEEE vectors used, integer stand-in otherwise
  function automatic logic [32:0] aluFunc(input logic op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    logic [32:0] sum;
    if (op && a == 32'h3FC0_0000 && b == 32'h4000_0000) return {1'b0, 32'h4040_0000};
    if (!op && a == 32'h3F80_0000 && b == 32'h3F80_0000) return {1'b0, 32'h4000_0000};
    prod = 64'(a) * 64'(b);
    sum  = 33'(a) + 33'(b);
    if (op) return {|prod[63:32], prod[31:0]};
    return sum;
  endfunction

  // Stand-in fpalu: restarts while alu_rst_n is low, then raises done stubLat cycles into WAIT
  always @(posedge clock) begin
    if (!alu_rst_n) begin
      stubCnt   <= 0;
      stubArmed <= 1'b1;
      if (stubMode == STALE) begin
        alu_done   <= 1'b1;
        alu_result <= 32'hDEAD_BEEF;
        alu_flow   <= 1'b1;
      end else begin
        alu_done <= 1'b0;
      end
    end else if (stubArmed && stubMode != STUCK) begin
      stubCnt <= stubCnt + 1;
      if (stubCnt == stubLat - 1) begin
        {alu_flow, alu_result} <= aluFunc(alu_op, alu_a, alu_b);
        alu_done  <= 1'b1;
        stubArmed <= 1'b0;
      end
    end
  end

  // Transaction-level model state
  bit          pend [2];
  logic        pOp  [2];
  logic [31:0] pA   [2];
  logic [31:0] pB   [2];
  bit          lastGrant = 1'b1;
  bit          busy = 1'b0;
  int          k = 0;
  int          curLat = 0;
  int          hold = 0;
  int          holdMinCur = 0;
  int          holdMaxCur = 0;
  int          completed = 0;
  int          pattern = 0;
  logic        curId, curOp;
  logic [31:0] curA, curB, expRes;
  logic        expFlow, expTo;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req0_ready"}, 32'(req0_ready), 32'd0);
    checkOutput({tag, "_req1_ready"}, 32'(req1_ready), 32'd0);
    checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    checkOutput({tag, "_rsp_result"}, rsp_result, 32'd0);
    checkOutput({tag, "_rsp_flow"}, 32'(rsp_flow), 32'd0);
    checkOutput({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'd0);
    checkOutput({tag, "_alu_a"}, alu_a, 32'd0);
    checkOutput({tag, "_alu_b"}, alu_b, 32'd0);
    checkOutput({tag, "_alu_op"}, 32'(alu_op), 32'd0);
    checkOutput({tag, "_alu_rst_n"}, 32'(alu_rst_n), 32'd0);
  endtask

  task automatic newReq(input int p);
    pend[p] = 1'b1;
    if (pattern == 1) begin
      pOp[p] = (p == 0);
      pA[p]  = (p == 0) ? 32'h3FC0_0000 : 32'h3F80_0000;
      pB[p]  = (p == 0) ? 32'h4000_0000 : 32'h3F80_0000;
    end else if (pattern == 2) begin
      pOp[p] = (p == 1);
      pA[p]  = (p == 1) ? 32'h3FC0_0000 : 32'h3F80_0000;
      pB[p]  = (p == 1) ? 32'h4000_0000 : 32'h3F80_0000;
    end else if ($urandom_range(0, 3) == 0) begin
      pOp[p] = 1'($urandom_range(0, 1));
      pA[p]  = pOp[p] ? 32'h3FC0_0000 : 32'h3F80_0000;
      pB[p]  = pOp[p] ? 32'h4000_0000 : 32'h3F80_0000;
    end else begin
      pOp[p] = 1'($urandom_range(0, 1));
      pA[p]  = $urandom;
      pB[p]  = $urandom;
    end
  endtask

  // One clock of the environment: drive, sample at negedge, advance past posedge
  task automatic cycleStep();
    logic eg, e0, e1;
    int   id;
    req0_valid = pend[0]; req0_op = pOp[0]; req0_a = pA[0]; req0_b = pB[0];
    req1_valid = pend[1]; req1_op = pOp[1]; req1_a = pA[1]; req1_b = pB[1];
    if (busy && k + 1 >= curLat) begin
      if (hold > 0) begin
        rsp_ready = 1'b0;
        hold--;
      end else begin
        rsp_ready = 1'b1;
      end
    end else begin
      rsp_ready = 1'($urandom_range(0, 1));
    end

    @(negedge clock);
    eg = (pend[0] && pend[1]) ? ~lastGrant : pend[1];
    e0 = !busy && pend[0] && !eg;
    e1 = !busy && pend[1] && eg;
    checkOutput("req0_ready", 32'(req0_ready), 32'(e0));
    checkOutput("req1_ready", 32'(req1_ready), 32'(e1));
    if (busy) begin
      k++;
      if (k == 1) begin
        checkOutput("clear_alu_rst_n", 32'(alu_rst_n), 32'd0);
        checkOutput("clear_alu_a", alu_a, curA);
        checkOutput("clear_alu_b", alu_b, curB);
        checkOutput("clear_alu_op", 32'(alu_op), 32'(curOp));
      end
      if (k == 2) checkOutput("wait_alu_rst_n", 32'(alu_rst_n), 32'd1);
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(k >= curLat));
      if (k >= curLat) begin
        checkOutput("rsp_id", 32'(rsp_id), 32'(curId));
        checkOutput("rsp_result", rsp_result, expRes);
        checkOutput("rsp_flow", 32'(rsp_flow), 32'(expFlow));
        checkOutput("rsp_timeout", 32'(rsp_timeout), 32'(expTo));
        checkOutput("held_alu_op", 32'(alu_op), 32'(curOp));
        checkOutput("held_alu_a", alu_a, curA);
        if (rsp_ready) begin
          busy = 1'b0;
          completed++;
        end
      end
    end else begin
      checkOutput("rsp_valid_idle", 32'(rsp_valid), 32'd0);
    end

    if (e0 || e1) begin
      id        = e1 ? 1 : 0;
      busy      = 1'b1;
      k         = 0;
      curId     = 1'(id);
      curOp     = pOp[id];
      curA      = pA[id];
      curB      = pB[id];
      pend[id]  = 1'b0;
      lastGrant = 1'(id);
      hold      = $urandom_range(holdMinCur, holdMaxCur);
      if (stubMode == STUCK) begin
        curLat  = 3 + TIMEOUT_CYC - 1;
        expRes  = 32'd0;
        expFlow = 1'b0;
        expTo   = 1'b1;
      end else begin
        stubLat = (stubMode == STALE) ? SETTLE_CYC : $urandom_range(1, 5);
        curLat  = 3 + ((stubLat > SETTLE_CYC) ? stubLat : SETTLE_CYC);
        {expFlow, expRes} = aluFunc(curOp, curA, curB);
        expTo   = 1'b0;
      end
    end

    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input int nOps, input logic [1:0] mask, input int pat, input int pct,
                               input stub_mode_t mode, input int holdMin, input int holdMax);
    int created = 0;
    int guard   = 0;
    int nNew;
    pattern    = pat;
    stubMode   = mode;
    holdMinCur = holdMin;
    holdMaxCur = holdMax;
    completed  = 0;
    nNew       = nOps - int'(pend[0]) - int'(pend[1]);
    while (completed < nOps && guard < 3000) begin
      guard++;
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && !busy && mask[p] && created < nNew && $urandom_range(0, 99) < pct) begin
          newReq(p);
          created++;
        end
      end
      cycleStep();
    end
    checkOutput("ops_completed", 32'(completed), 32'(nOps));
  endtask

  initial begin
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    checkResetOutputs("por");
    @(posedge clock);
    #1 reset = 1'b1;

    $display("[TB] port 0 multiply 1.5*2.0");
    applyStimulus(1, 2'b01, 1, 100, NORMAL, 0, 0);
    $display("[TB] port 1 add 1.0+1.0");
    applyStimulus(1, 2'b10, 1, 100, NORMAL, 0, 0);
    $display("[TB] both ports contending");
    applyStimulus(4, 2'b11, 2, 100, NORMAL, 0, 1);
    $display("[TB] stale done from datapath");
    applyStimulus(3, 2'b11, 0, 60, STALE, 0, 2);
    $display("[TB] watchdog");
    applyStimulus(2, 2'b11, 0, 100, STUCK, 0, 1);
    $display("[TB] response back-pressure");
    applyStimulus(2, 2'b11, 0, 100, NORMAL, 10, 10);

    $display("[TB] reset during WAIT");
    stubMode = STUCK;
    pattern  = 0;
    newReq(1);
    for (int g = 0; g < 20 && !(busy && k >= 4); g++) cycleStep();
    checkOutput("reached_wait", 32'(busy), 32'd1);
    reset = 1'b0;
    busy  = 1'b0;
    newReq(0);
    newReq(1);
    req0_valid = 1'b1; req0_op = pOp[0]; req0_a = pA[0]; req0_b = pB[0];
    req1_valid = 1'b1; req1_op = pOp[1]; req1_a = pA[1]; req1_b = pB[1];
    @(negedge clock);
    checkResetOutputs("midop");
    @(posedge clock);
    #1 reset = 1'b1;
    lastGrant = 1'b1;
    applyStimulus(2, 2'b11, 0, 100, NORMAL, 0, 2);

    $display("[TB] random traffic");
    applyStimulus(40, 2'b11, 0, 50, NORMAL, 0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
